// File: rtl/chunk_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : chunk_serial_adder
// Description : Multi-cycle WIDTH-bit adder that reuses one CHUNK-bit
//               carry-lookahead slice per cycle, LSB chunk first, with a
//               start/busy/done handshake and registered sum/cout/ovf.
// Revision    : 1.0 - initial release
// ============================================================================
module chunk_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int c_N  = WIDTH / CHUNK;
    localparam int c_KW = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_KW-1:0] c_LAST = c_KW'(c_N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_c;
    logic [c_KW-1:0]  r_k;

    logic [31:0]      w_base;
    logic             w_last;
    logic [CHUNK-1:0] w_ca;
    logic [CHUNK-1:0] w_cb;
    logic [CHUNK-1:0] w_g;
    logic [CHUNK-1:0] w_p;
    logic [CHUNK:0]   w_c;
    logic [CHUNK-1:0] w_s;
    logic             w_pp;
    logic [WIDTH-1:0] w_acc_next;

    // Select the operand chunk currently fed into the slice
    always_comb begin
        w_base = 32'(r_k) * CHUNK;
        w_last = (r_k == c_LAST);
        w_ca   = r_a[w_base +: CHUNK];
        w_cb   = r_b[w_base +: CHUNK];
        w_g    = w_ca & w_cb;
        w_p    = w_ca ^ w_cb;
    end

    // Lookahead carries: each c[i+1] is a flat sum of products over g/p and
    // the chunk carry-in, so no carry depends on a neighbouring carry.
    always_comb begin
        w_c    = '0;
        w_pp   = 1'b1;
        w_c[0] = r_c;
        for (int i = 0; i < CHUNK; i++) begin
            w_pp = 1'b1;
            for (int j = i; j >= 0; j--) begin
                w_c[i+1] = w_c[i+1] | (w_g[j] & w_pp);
                w_pp     = w_pp & w_p[j];
            end
            w_c[i+1] = w_c[i+1] | (w_pp & r_c);
        end
    end

    // Chunk sum merged into the accumulator image
    always_comb begin
        w_s                          = w_p ^ w_c[CHUNK-1:0];
        w_acc_next                   = r_acc;
        w_acc_next[w_base +: CHUNK]  = w_s;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Operand capture, per-chunk accumulation and final result load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_c   <= 1'b0;
            r_k   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_c   <= cin;
                        r_k   <= '0;
                        r_acc <= '0;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_next;
                    r_c   <= w_c[CHUNK];
                    if (w_last) begin
                        sum  <= w_acc_next;
                        cout <= w_c[CHUNK];
                        // carry into the MSB xor carry out of the MSB
                        ovf  <= w_c[CHUNK-1] ^ w_c[CHUNK];
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
